// File: rtl/sigma_accel_pkg.sv
// rtl/sigma_accel_pkg.sv - register map, status/ctrl bit positions and FSM states for sigma_accel_ctrl
package sigma_accel_pkg;

    // Word index of each register (byte address bits [3:2] relative to BASE_ADDR)
    localparam logic [1:0] REG_OPERAND = 2'd0;
    localparam logic [1:0] REG_RESULT  = 2'd1;
    localparam logic [1:0] REG_STATUS  = 2'd2;
    localparam logic [1:0] REG_CTRL    = 2'd3;

    // STATUS bit positions
    localparam int ST_BUSY       = 0;
    localparam int ST_IN_FULL    = 1;
    localparam int ST_OUT_EMPTY  = 2;
    localparam int ST_OVF_ERR    = 3;
    localparam int ST_UDF_ERR    = 4;
    localparam int ST_IRQ_EN     = 5;
    localparam int ST_IN_CNT_LSB  = 8;
    localparam int ST_OUT_CNT_LSB = 16;

    // CTRL bit positions
    localparam int CTRL_FLUSH   = 0;
    localparam int CTRL_CLR_ERR = 1;
    localparam int CTRL_IRQ_EN  = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        CAPT = 2'd2
    } state_e;

endpackage

// File: rtl/sigma_accel_fifo.sv
// rtl/sigma_accel_fifo.sv - 32-bit synchronous FIFO with push/pop/flush and full/empty/count
//
// Ports: clk, rst_n (async active-low), flush (empties, wins over push),
//        push/push_data, pop/pop_data (head, valid while !empty), full, empty, count.
// A push into a full FIFO succeeds when a pop happens in the same cycle.
module sigma_accel_fifo
    import sigma_accel_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        push,
    input  logic [31:0] push_data,
    input  logic        pop,
    output logic [31:0] pop_data,
    output logic        full,
    output logic        empty,
    output logic [7:0]  count
);

    localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [7:0] DEPTH_C = 8'(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty    = (count == 8'd0);
    assign full     = (count == DEPTH_C);
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so pointers wrap naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= 8'd0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= 8'd0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 8'd1;
                2'b01:   count <= count - 8'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sigma_accel_ctrl.sv
// rtl/sigma_accel_ctrl.sv - CSR-mapped sequencer feeding a fixed-latency scalar accelerator
//
// Ports: clk_i, arst_ni (async active-low); xif bus bus_req_i/bus_we_i/bus_addr_i/bus_wdata_i
//        -> bus_ack_o/bus_resp_o/bus_rdata_o; accelerator acc_x_o -> acc_y_i;
//        irq_o only when SIGMA_ACCEL_IRQ_EN is defined.
// Registers: +0x0 OPERAND (W push), +0x4 RESULT (R pop), +0x8 STATUS (R), +0xC CTRL (W).
module sigma_accel_ctrl
    import sigma_accel_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h80000100,
    parameter int          FIFO_DEPTH = 4,
    parameter int          LATENCY    = 4
) (
    input  logic        clk_i,
    input  logic        arst_ni,
    input  logic        bus_req_i,
    input  logic        bus_we_i,
    input  logic [31:0] bus_addr_i,
    input  logic [31:0] bus_wdata_i,
    output logic        bus_ack_o,
    output logic        bus_resp_o,
    output logic [31:0] bus_rdata_o,
    output logic [31:0] acc_x_o,
    input  logic [31:0] acc_y_i
`ifdef SIGMA_ACCEL_IRQ_EN
    ,
    output logic        irq_o
`endif
);

    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_e        state;
    logic [CW-1:0] cnt;

    logic          hit, wr, rd;
    logic [1:0]    reg_sel;
    logic          operand_wr, ctrl_wr, result_rd, status_rd;
    logic          flush;
    logic          in_pop, out_push;
    logic [31:0]   in_data, out_data;
    logic          in_full, in_empty, out_full, out_empty;
    logic [7:0]    in_count, out_count;
    logic          ovf_err, udf_err, irq_en;
    logic [31:0]   status, rdata_next;
    logic [28:0]   unused_wdata;

    assign bus_ack_o = bus_req_i;

    // Word-aligned hits inside the 16-byte block only
    assign hit        = bus_req_i && (bus_addr_i[31:4] == BASE_ADDR[31:4]) && (bus_addr_i[1:0] == 2'b00);
    assign reg_sel    = bus_addr_i[3:2];
    assign wr         = hit & bus_we_i;
    assign rd         = hit & ~bus_we_i;
    assign operand_wr = wr & (reg_sel == REG_OPERAND);
    assign ctrl_wr    = wr & (reg_sel == REG_CTRL);
    assign result_rd  = rd & (reg_sel == REG_RESULT);
    assign status_rd  = rd & (reg_sel == REG_STATUS);
    assign flush      = ctrl_wr & bus_wdata_i[CTRL_FLUSH];
    assign unused_wdata = bus_wdata_i[31:3];

    // Issue only with a free out slot: at most one op is in flight, so CAPT always fits
    assign in_pop   = (state == IDLE) & ~in_empty & ~out_full & ~flush;
    assign out_push = (state == CAPT) & ~flush;

    sigma_accel_fifo #(.DEPTH(FIFO_DEPTH)) u_in_fifo (
        .clk       (clk_i),
        .rst_n     (arst_ni),
        .flush     (flush),
        .push      (operand_wr),
        .push_data (bus_wdata_i),
        .pop       (in_pop),
        .pop_data  (in_data),
        .full      (in_full),
        .empty     (in_empty),
        .count     (in_count)
    );

    sigma_accel_fifo #(.DEPTH(FIFO_DEPTH)) u_out_fifo (
        .clk       (clk_i),
        .rst_n     (arst_ni),
        .flush     (flush),
        .push      (out_push),
        .push_data (acc_y_i),
        .pop       (result_rd),
        .pop_data  (out_data),
        .full      (out_full),
        .empty     (out_empty),
        .count     (out_count)
    );

    // Sequencer: operand held in acc_x_o from issue; result sampled LATENCY cycles later
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state   <= IDLE;
            cnt     <= '0;
            acc_x_o <= 32'd0;
        end else if (flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (in_pop) begin
                        acc_x_o <= in_data;
                        cnt     <= CW'(LATENCY - 1);
                        state   <= RUN;
                    end
                end
                RUN: begin
                    if (cnt == '0) state <= CAPT;
                    else           cnt   <= cnt - 1'b1;
                end
                CAPT:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Sticky errors; an OPERAND write into a full FIFO still lands if the FSM pops that cycle
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            ovf_err <= 1'b0;
            udf_err <= 1'b0;
        end else begin
            if (ctrl_wr && bus_wdata_i[CTRL_CLR_ERR]) begin
                ovf_err <= 1'b0;
                udf_err <= 1'b0;
            end
            if (operand_wr && in_full && !in_pop) ovf_err <= 1'b1;
            if (result_rd && out_empty)           udf_err <= 1'b1;
        end
    end

`ifdef SIGMA_ACCEL_IRQ_EN
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            irq_en <= 1'b0;
            irq_o  <= 1'b0;
        end else begin
            if (ctrl_wr) irq_en <= bus_wdata_i[CTRL_IRQ_EN];
            irq_o <= irq_en & ((out_count != 8'd0) | ovf_err | udf_err);
        end
    end
`else
    assign irq_en = 1'b0;
`endif

    always_comb begin
        status                                 = 32'd0;
        status[ST_BUSY]                        = (state != IDLE);
        status[ST_IN_FULL]                     = in_full;
        status[ST_OUT_EMPTY]                   = out_empty;
        status[ST_OVF_ERR]                     = ovf_err;
        status[ST_UDF_ERR]                     = udf_err;
        status[ST_IRQ_EN]                      = irq_en;
        status[ST_IN_CNT_LSB +: 8]             = in_count;
        status[ST_OUT_CNT_LSB +: 8]            = out_count;
    end

    always_comb begin
        rdata_next = 32'd0;
        if (result_rd && !out_empty) rdata_next = out_data;
        else if (status_rd)          rdata_next = status;
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            bus_resp_o  <= 1'b0;
            bus_rdata_o <= 32'd0;
        end else begin
            bus_resp_o  <= result_rd | status_rd;
            bus_rdata_o <= rdata_next;
        end
    end

endmodule
